alu_8bit_ctrl: RTL and testbench
================================

# alu_8bit_ctrl

Command sequencer and operand register file wrapped around the 8-bit combinational ALU. It accepts one ALU command at a time over a valid/ready handshake. It reads both operands from a 4×8-bit register file and drives the ALU inputs from registers. It captures the ALU result and flags one cycle later, optionally writes the result back, and reports completion. It is the sole producer of ALU operands and the sole consumer of ALU result and flags.

## Interface
- No parameters. Data width is fixed at 8, register count at 4, opcode width at 3, matching the ALU.
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  high only in IDLE with i_rst_n high
- i_cmd_op  in  3  ALU opcode, passed unchanged to ALU
- i_cmd_ra / i_cmd_rb  in  2 each  source register for ALU a / b
- i_cmd_rd  in  2  destination register
- i_cmd_wr  in  1  1 = write result to rd
- i_ld_valid, i_ld_addr[1:0], i_ld_data[7:0]  in  direct register load, honoured only in IDLE
- i_rd_addr  in  2  debug read address; o_rd_data  out  8  = regs[i_rd_addr], combinational
- o_alu_a, o_alu_b  out  8  registered operands to ALU; o_alu_op  out  3  registered opcode
- i_alu_result  in  8  ALU result; i_alu_flag  in  8  ALU flag vector
- o_result  out  8  last captured result; o_flag  out  8  last captured flags
- o_done  out  1  one-cycle pulse per completed command
- o_ovf_sticky  out  1  set by any captured flag[0]; i_clr_sticky  in  1  clears it
- o_cmd_cnt  out  8  completed-command counter, wraps 0xFF→0x00

## Operation
- FSM states: IDLE → EXEC → DONE → IDLE.
- IDLE:
  - If i_cmd_valid: latch op, rd, wr; load o_alu_a=regs[ra], o_alu_b=regs[rb], o_alu_op=op; go to EXEC.
  - i_ld_valid without i_cmd_valid: regs[i_ld_addr] ← i_ld_data.
  - i_ld_valid together with i_cmd_valid: the command is accepted, and the load is also performed.
  - Operands sample pre-load register contents. A load to ra/rb in the same cycle does not forward.
- EXEC:
  - o_result ← i_alu_result; o_flag ← i_alu_flag.
  - If wr: regs[rd] ← i_alu_result. This includes op 7, which writes 0x00.
  - If i_alu_flag[0]: o_ovf_sticky ← 1.
  - Go to DONE. i_ld_valid is ignored.
- DONE:
  - o_done=1; o_cmd_cnt ← o_cmd_cnt+1; go to IDLE. i_ld_valid is ignored.
- o_alu_a/b/op hold their values outside the accept edge.
- i_clr_sticky:
  - Clears o_ovf_sticky in any state.
  - If a set occurs in the same cycle, set wins.
- No hazards: writeback completes before the next command can read registers.

## Timing
- Command accepted on edge N (valid & ready).
- ALU inputs are valid during cycle N+1, and the capture/writeback edge is N+1.
- o_done is high during cycle N+2, and o_cmd_ready is high again from cycle N+3.
- Throughput is 1 command per 3 cycles; o_cmd_ready is low in EXEC and DONE.
- A command held valid while not ready is accepted on the first IDLE edge.
- Reset, when i_rst_n is low at an edge:
  - State → IDLE.
  - regs, o_alu_a/b/op, o_result, o_flag, o_ovf_sticky, o_cmd_cnt all → 0.
  - o_done → 0.
- o_cmd_ready is forced 0 while i_rst_n is low.
- Reset in EXEC or DONE aborts the command: no writeback, no o_done, no count.

## Test plan
- Load r0=0x7F, r1=0x01. Issue cmd op=0, ra=0, rb=1, rd=2, wr=1. Expect o_done 2 cycles after accept, o_result=0x80, o_flag=0x01, regs[2]=0x80, o_ovf_sticky=1, o_cmd_cnt=1.
- Load r0=0x05. Issue op=1, ra=0, rb=0, rd=3, wr=0. Expect o_result=0x00, o_flag=0x02, regs[3] unchanged.
- op=7, ra=0, rb=1 with r0=0x10, r1=0x20, rd=1, wr=1. Expect o_flag=0x80 and regs[1]=0x00.
- Hold i_cmd_valid high for 9 cycles after reset release. Expect exactly 3 accepts, o_cmd_ready pattern 1,0,0 repeating, o_cmd_cnt=3.
- Assert i_ld_valid (addr 0, 0xAA) during EXEC. Expect r0 unchanged. Assert i_clr_sticky and a flag[0] capture in the same cycle. Expect sticky stays 1.
- Drop i_rst_n during EXEC of a wr=1 cmd. Expect no write to rd, no o_done, and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/alu_8bit_ctrl_if.sv
// Command handshake bundle between a command source and the ALU sequencer.
// The master issues ALU commands; the slave (sequencer) returns ready.
interface alu_8bit_ctrl_if;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [2:0] i_cmd_op;
  logic [1:0] i_cmd_ra;
  logic [1:0] i_cmd_rb;
  logic [1:0] i_cmd_rd;
  logic       i_cmd_wr;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_ra, i_cmd_rb, i_cmd_rd, i_cmd_wr,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_ra, i_cmd_rb, i_cmd_rd, i_cmd_wr,
    output o_cmd_ready
  );
endinterface

// File: rtl/alu_8bit_ctrl.sv
// Sequencer and 4x8 operand register file around the combinational 8-bit ALU.
// One command per three cycles: accept (IDLE), capture/writeback (EXEC), report (DONE).
module alu_8bit_ctrl (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_8bit_ctrl_if.slave       cmd,
  input  logic                 i_ld_valid,
  input  logic [1:0]           i_ld_addr,
  input  logic [7:0]           i_ld_data,
  input  logic [1:0]           i_rd_addr,
  output logic [7:0]           o_rd_data,
  output logic [7:0]           o_alu_a,
  output logic [7:0]           o_alu_b,
  output logic [2:0]           o_alu_op,
  input  logic [7:0]           i_alu_result,
  input  logic [7:0]           i_alu_flag,
  output logic [7:0]           o_result,
  output logic [7:0]           o_flag,
  output logic                 o_done,
  output logic                 o_ovf_sticky,
  input  logic                 i_clr_sticky,
  output logic [7:0]           o_cmd_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0][7:0] regs;
  logic [1:0]      rd_q;
  logic            wr_q;
  logic            ready;
  logic            done;
  logic            accept;
  logic            ovf_set;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Ready/done are gated by reset so an aborted command never reports.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = i_rst_n;
        if (cmd.i_cmd_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        done      = i_rst_n;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd.o_cmd_ready = ready;
  assign o_done          = done;
  assign accept          = cmd.i_cmd_valid & ready;
  assign ovf_set         = (state == EXEC) & i_alu_flag[0];
  assign o_rd_data       = regs[i_rd_addr];

  // Direct loads only land in IDLE; writeback only in EXEC, so they never collide.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      regs <= '0;
    else if (state == IDLE && i_ld_valid)
      regs[i_ld_addr] <= i_ld_data;
    else if (state == EXEC && wr_q)
      regs[rd_q] <= i_alu_result;
  end

  // Operands sample the register file before any same-edge load.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_alu_a  <= '0;
      o_alu_b  <= '0;
      o_alu_op <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
    end else if (accept) begin
      o_alu_a  <= regs[cmd.i_cmd_ra];
      o_alu_b  <= regs[cmd.i_cmd_rb];
      o_alu_op <= cmd.i_cmd_op;
      rd_q     <= cmd.i_cmd_rd;
      wr_q     <= cmd.i_cmd_wr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_result <= '0;
      o_flag   <= '0;
    end else if (state == EXEC) begin
      o_result <= i_alu_result;
      o_flag   <= i_alu_flag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)          o_ovf_sticky <= 1'b0;
    else if (ovf_set)      o_ovf_sticky <= 1'b1;
    else if (i_clr_sticky) o_ovf_sticky <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           o_cmd_cnt <= '0;
    else if (state == DONE) o_cmd_cnt <= o_cmd_cnt + 8'd1;
  end

endmodule

// File: tb/tb_alu_8bit_ctrl.sv
// Bench for alu_8bit_ctrl: a stand-in ALU, vector table, scoreboard queue
// checked on each o_done, and directed sequences for reset/hold/sticky corners.
module tb_alu_8bit_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ld_valid = 1'b0;
  logic [1:0] i_ld_addr = '0;
  logic [7:0] i_ld_data = '0;
  logic [1:0] i_rd_addr = '0;
  logic [7:0] o_rd_data;
  logic [7:0] o_alu_a, o_alu_b;
  logic [2:0] o_alu_op;
  logic [7:0] alu_res, alu_flag;
  logic [7:0] o_result, o_flag;
  logic       o_done, o_ovf_sticky;
  logic       i_clr_sticky = 1'b0;
  logic [7:0] o_cmd_cnt;

  alu_8bit_ctrl_if cmd_if ();

  alu_8bit_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .cmd          (cmd_if),
    .i_ld_valid   (i_ld_valid),
    .i_ld_addr    (i_ld_addr),
    .i_ld_data    (i_ld_data),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (alu_res),
    .i_alu_flag   (alu_flag),
    .o_result     (o_result),
    .o_flag       (o_flag),
    .o_done       (o_done),
    .o_ovf_sticky (o_ovf_sticky),
    .i_clr_sticky (i_clr_sticky),
    .o_cmd_cnt    (o_cmd_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Stand-in ALU: flag[0] signed overflow (add/sub), flag[1] zero, op 7 clears with flag 0x80.
  always_comb begin
    alu_res  = '0;
    alu_flag = '0;
    case (o_alu_op)
      3'd0: begin
        alu_res     = o_alu_a + o_alu_b;
        alu_flag[0] = (o_alu_a[7] == o_alu_b[7]) && (alu_res[7] != o_alu_a[7]);
      end
      3'd1: begin
        alu_res     = o_alu_a - o_alu_b;
        alu_flag[0] = (o_alu_a[7] != o_alu_b[7]) && (alu_res[7] != o_alu_a[7]);
      end
      3'd2: alu_res = o_alu_a & o_alu_b;
      3'd3: alu_res = o_alu_a | o_alu_b;
      3'd4: alu_res = o_alu_a ^ o_alu_b;
      3'd5: alu_res = {o_alu_a[6:0], 1'b0};
      3'd6: alu_res = {1'b0, o_alu_a[7:1]};
      default: ;
    endcase
    if (o_alu_op == 3'd7) alu_flag = 8'h80;
    else                  alu_flag[1] = (alu_res == 8'h00);
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] ra, rb, rd;
    logic       wr;
    logic [7:0] a, b, res, flag;
  } vec_t;

  typedef struct {
    logic [7:0] res, flag;
    logic [1:0] rd;
    logic       wr;
    int         acc;
  } exp_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  exp_t       sbq[$];
  logic [7:0] mdl_regs [4];
  logic [7:0] mdl_cnt = '0;
  logic       mdl_sticky = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every o_done must match the oldest outstanding command.
  always @(negedge i_clk) begin
    if (o_done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got o_done=1 want 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", o_result, e.res);
        chk("flag", o_flag, e.flag);
        chk("done_latency", cyc, e.acc + 2);
        chk("cmd_cnt", o_cmd_cnt, mdl_cnt);
        mdl_cnt = mdl_cnt + 8'd1;
        mdl_sticky = mdl_sticky | e.flag[0];
        chk("sticky", o_ovf_sticky, mdl_sticky);
        if (e.wr) mdl_regs[e.rd] = e.res;
      end
    end
  end

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge i_clk);
    i_ld_valid = 1'b1;
    i_ld_addr  = a;
    i_ld_data  = d;
    @(posedge i_clk);
    #1 i_ld_valid = 1'b0;
    mdl_regs[a] = d;
  endtask

  // Returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic wr, input logic ld_en,
                       input logic [1:0] ld_a, input logic [7:0] ld_d,
                       input logic [7:0] er, input logic [7:0] ef, input bit push);
    bit got = 0;
    @(negedge i_clk);
    cmd_if.i_cmd_valid = 1'b1;
    cmd_if.i_cmd_op    = op;
    cmd_if.i_cmd_ra    = ra;
    cmd_if.i_cmd_rb    = rb;
    cmd_if.i_cmd_rd    = rd;
    cmd_if.i_cmd_wr    = wr;
    i_ld_valid = ld_en;
    i_ld_addr  = ld_a;
    i_ld_data  = ld_d;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) @(negedge i_clk);
      if (cmd_if.o_cmd_ready) begin
        got = 1;
        if (push) sbq.push_back('{er, ef, rd, wr, cyc});
        if (ld_en) mdl_regs[ld_a] = ld_d;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no ready want ready within 20 cycles");
    end
    @(posedge i_clk);
    #1;
    cmd_if.i_cmd_valid = 1'b0;
    i_ld_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_clk);
      if (cmd_if.o_cmd_ready) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy want idle within 20 cycles");
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 4; r++) mdl_regs[r] = '0;
    mdl_cnt = '0;
    mdl_sticky = 1'b0;
    sbq.delete();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    cmd_if.i_cmd_valid = 1'b0;
    i_ld_valid = 1'b0;
    i_clr_sticky = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    clear_model();
    chk("rst_ready", cmd_if.o_cmd_ready, 0);
    chk("rst_done", o_done, 0);
    chk("rst_result", o_result, 0);
    chk("rst_flag", o_flag, 0);
    chk("rst_alu_a", o_alu_a, 0);
    chk("rst_alu_op", o_alu_op, 0);
    chk("rst_sticky", o_ovf_sticky, 0);
    chk("rst_cnt", o_cmd_cnt, 0);
    i_rd_addr = 2'd2;
    #1 chk("rst_reg2", o_rd_data, 0);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   accepts;

    vecs[0] = '{3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 8'h7F, 8'h01, 8'h80, 8'h01};
    vecs[1] = '{3'd1, 2'd0, 2'd0, 2'd3, 1'b0, 8'h05, 8'h05, 8'h00, 8'h02};
    vecs[2] = '{3'd7, 2'd0, 2'd1, 2'd1, 1'b1, 8'h10, 8'h20, 8'h00, 8'h80};
    vecs[3] = '{3'd2, 2'd1, 2'd2, 2'd0, 1'b1, 8'hF0, 8'h3C, 8'h30, 8'h00};
    vecs[4] = '{3'd3, 2'd2, 2'd3, 2'd1, 1'b1, 8'h0F, 8'hF0, 8'hFF, 8'h00};
    vecs[5] = '{3'd4, 2'd3, 2'd0, 2'd2, 1'b0, 8'hAA, 8'hAA, 8'h00, 8'h02};
    vecs[6] = '{3'd1, 2'd0, 2'd1, 2'd0, 1'b1, 8'h80, 8'h01, 8'h7F, 8'h01};
    vecs[7] = '{3'd6, 2'd2, 2'd3, 2'd3, 1'b1, 8'h01, 8'h00, 8'h00, 8'h02};

    cmd_if.i_cmd_valid = 1'b0;
    cmd_if.i_cmd_op = '0;
    cmd_if.i_cmd_ra = '0;
    cmd_if.i_cmd_rb = '0;
    cmd_if.i_cmd_rd = '0;
    cmd_if.i_cmd_wr = 1'b0;
    clear_model();

    // Valid held across reset release: accepts every third cycle.
    do_reset();
    cmd_if.i_cmd_valid = 1'b1;
    accepts = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("hold_ready", cmd_if.o_cmd_ready, (i % 3 == 0) ? 1 : 0);
      if (cmd_if.o_cmd_ready) begin
        accepts++;
        sbq.push_back('{8'h00, 8'h02, 2'd0, 1'b0, cyc});
      end
      @(negedge i_clk);
    end
    cmd_if.i_cmd_valid = 1'b0;
    chk("hold_accepts", accepts, 3);
    chk("hold_cnt", o_cmd_cnt, 3);

    for (int v = 0; v < 8; v++) begin
      load(vecs[v].ra, vecs[v].a);
      load(vecs[v].rb, vecs[v].b);
      issue(vecs[v].op, vecs[v].ra, vecs[v].rb, vecs[v].rd, vecs[v].wr,
            1'b0, 2'd0, 8'h00, vecs[v].res, vecs[v].flag, 1'b1);
      wait_idle();
      i_rd_addr = vecs[v].rd;
      #1 chk("vec_rd_reg", o_rd_data, mdl_regs[vecs[v].rd]);
    end

    // Same-edge load to the source register must not forward into the operand.
    load(2'd0, 8'h11);
    issue(3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 2'd0, 8'h22, 8'h22, 8'h00, 1'b1);
    wait_idle();
    i_rd_addr = 2'd0;
    #1 chk("same_edge_load_r0", o_rd_data, 8'h22);

    // Sticky clear in IDLE, then set-vs-clear collision and a load during EXEC.
    @(negedge i_clk);
    i_clr_sticky = 1'b1;
    @(posedge i_clk);
    #1 i_clr_sticky = 1'b0;
    mdl_sticky = 1'b0;
    chk("sticky_cleared", o_ovf_sticky, 0);
    load(2'd0, 8'h7F);
    load(2'd1, 8'h01);
    issue(3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 8'h00, 8'h80, 8'h01, 1'b1);
    @(negedge i_clk);
    i_ld_valid   = 1'b1;
    i_ld_addr    = 2'd0;
    i_ld_data    = 8'hAA;
    i_clr_sticky = 1'b1;
    @(negedge i_clk);
    i_ld_valid   = 1'b0;
    i_clr_sticky = 1'b0;
    i_rd_addr    = 2'd0;
    #1;
    chk("exec_load_ignored", o_rd_data, 8'h7F);
    chk("sticky_set_wins", o_ovf_sticky, 1);
    wait_idle();

    // Counter wrap through 0xFF.
    load(2'd0, 8'h01);
    for (int k = 0; k < 260; k++) begin
      issue(3'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 2'd0, 8'h00, 8'h02, 8'h00, 1'b1);
      wait_idle();
    end
    chk("wrap_cnt", o_cmd_cnt, mdl_cnt);

    // Reset during EXEC aborts the command.
    load(2'd0, 8'h7F);
    load(2'd1, 8'h01);
    issue(3'd0, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rd_addr = 2'd3;
    #1;
    chk("abort_done", o_done, 0);
    chk("abort_ready", cmd_if.o_cmd_ready, 0);
    chk("abort_result", o_result, 0);
    chk("abort_flag", o_flag, 0);
    chk("abort_alu_b", o_alu_b, 0);
    chk("abort_sticky", o_ovf_sticky, 0);
    chk("abort_cnt", o_cmd_cnt, 0);
    chk("abort_rd_reg", o_rd_data, 0);
    clear_model();
    @(negedge i_clk);
    chk("abort_done_late", o_done, 0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("abort_cnt_after", o_cmd_cnt, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
